// File: rtl/spi_buffer_swap_ctrl_pkg.sv
// Shared definitions for the SPI/NITTA double-buffer swap controller:
// FSM state encoding, bank index constants and a bank-to-clear-mask helper.
package spi_buffer_swap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PENDING = 2'd1,
        ST_SWAP    = 2'd2
    } state_t;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    // One-hot clear mask for a bank index: bank A -> 2'b01, bank B -> 2'b10
    function automatic logic [1:0] bank_mask(input logic bank);
        return (bank == BANK_B) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus a history flop so
// rising/falling edges of the synchronized level can be detected.
module sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic q_d;

    // Synchronizer chain and one-cycle history of the synchronized level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
            q_d  <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
            q_d  <= q;
        end
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spi_buffer_swap_ctrl.sv
// Double-buffer swap controller between a NITTA processing unit and an SPI
// slave. The NITTA side writes bank_sel, the SPI side uses ~bank_sel. Banks
// are exchanged at a computational-cycle boundary, deferred while an SPI
// transaction is in progress (cs low).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | normal operation, waiting for signal_cycle
// ST_PENDING | cycle boundary seen during an SPI transaction, waiting cs high
// ST_SWAP    | one-cycle state in which the exchanged banks take effect
module spi_buffer_swap_ctrl
    import spi_buffer_swap_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int SPI_DATA_WIDTH = 8,
    parameter  int BUF_SIZE       = 6,
    localparam int BYTES          = DATA_WIDTH / SPI_DATA_WIDTH,
    localparam int BIDX_W         = (BYTES > 1) ? $clog2(BYTES) : 1,
    localparam int CNT_W          = $clog2(BUF_SIZE + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              signal_cycle,
    input  logic              nitta_wr,
    input  logic              cs,
    input  logic              spi_ready,
    output logic              bank_sel,
    output logic              swap,
    output logic [1:0]        clr_bank,
    output logic [BIDX_W-1:0] byte_idx,
    output logic              word_done,
    output logic [CNT_W-1:0]  spi_word_cnt,
    output logic [CNT_W-1:0]  nitta_word_cnt,
    output logic              flag_start,
    output logic              flag_stop,
    output logic [1:0]        err
);

    localparam logic [BIDX_W-1:0] BYTE_LAST = BIDX_W'(BYTES - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(BUF_SIZE);

    state_t state;
    logic   cs_s;
    logic   cs_rise;
    logic   cs_fall;
    logic   swap_go;
    logic   err_overrun;
    logic   err_overflow;

    // cs idles high, so the synchronizer resets to 1 and no edge follows reset
    sync_edge #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (cs),
        .q    (cs_s),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // A cs_s rising edge implies cs_s=1, so a coincident signal_cycle swaps
    assign swap_go = ((state == ST_RUN) && signal_cycle && cs_s) ||
                     ((state == ST_PENDING) && cs_s);

    assign err = {err_overflow, err_overrun};

    // Swap FSM with registered bank select, swap/clear pulses and pending flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_RUN;
            bank_sel    <= BANK_A;
            swap        <= 1'b0;
            clr_bank    <= 2'b00;
            flag_stop   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            swap     <= 1'b0;
            clr_bank <= 2'b00;
            if (swap_go) begin
                state     <= ST_SWAP;
                bank_sel  <= ~bank_sel;
                swap      <= 1'b1;
                clr_bank  <= bank_mask(~bank_sel);
                flag_stop <= 1'b0;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (signal_cycle) begin
                            state     <= ST_PENDING;
                            flag_stop <= 1'b1;
                        end
                    end
                    ST_PENDING: begin
                        if (signal_cycle) begin
                            err_overrun <= 1'b1;
                        end
                    end
                    ST_SWAP: begin
                        state <= ST_RUN;
                    end
                    default: begin
                        state     <= ST_RUN;
                        flag_stop <= 1'b0;
                    end
                endcase
            end
        end
    end

    // SPI byte/word tracking, NITTA write count and the overflow error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx       <= '0;
            word_done      <= 1'b0;
            spi_word_cnt   <= '0;
            nitta_word_cnt <= '0;
            flag_start     <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            word_done  <= 1'b0;
            flag_start <= cs_fall;
            if (swap_go) begin
                byte_idx       <= '0;
                spi_word_cnt   <= '0;
                nitta_word_cnt <= nitta_wr ? CNT_W'(1) : '0;
            end else begin
                if (cs_rise) begin
                    byte_idx <= '0;
                end else if (spi_ready && !cs_s) begin
                    if (byte_idx == BYTE_LAST) begin
                        byte_idx  <= '0;
                        word_done <= 1'b1;
                        if (spi_word_cnt != CNT_FULL) begin
                            spi_word_cnt <= spi_word_cnt + 1'b1;
                        end
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                if (nitta_wr) begin
                    if (nitta_word_cnt == CNT_FULL) begin
                        err_overflow <= 1'b1;
                    end else begin
                        nitta_word_cnt <= nitta_word_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule
